wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Writeback stage feeding the integer register file write port (we/waddr/wdata).
//   Arbitrates between a single-cycle ALU result and a buffered LSU load result.
//   Suppresses writes to x0 and drives one registered write per cycle into regfile.
// PARAMETERS
//   XLEN        32  data width
//   AW          5   register address width (32 architectural regs)
//   FIFO_DEPTH  4   LSU result queue depth; power of 2, >=2
//   STARVE_MAX  3   consecutive ALU-denied cycles before ALU is forced a grant; >=1
// PORTS
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous reset, active-high
//   hold       in   1     freeze: no grants while 1 (halt/debug)
//   alu_valid  in   1     ALU result valid
//   alu_ready  out  1     ALU result granted this cycle
//   alu_rd     in   AW    ALU destination register
//   alu_data   in   XLEN  ALU result
//   lsu_valid  in   1     LSU load result valid
//   lsu_ready  out  1     LSU queue can accept
//   lsu_rd     in   AW    LSU destination register
//   lsu_data   in   XLEN  LSU load data
//   we         out  1     regfile write enable (registered)
//   waddr      out  AW    regfile write address (registered)
//   wdata      out  XLEN  regfile write data (registered)
// BEHAVIOUR
//   - Reset: we=0, waddr=0, wdata=0, queue empty, starve count 0, alu_ready=0, lsu_ready=0 while rst=1.
//   - LSU: push on lsu_valid&lsu_ready; lsu_ready = !full & !rst. No fall-through: entry is arbitrable the cycle after push.
//   - Queue pointers wrap mod FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits; pop and push in the same cycle are legal.
//   - ALU is unbuffered: alu_ready is combinational, =1 only when the arbiter grants ALU this cycle.
//   - Arbiter (hold=0): queue head beats ALU. starve_cnt increments each cycle alu_valid=1 and not granted.
//     At starve_cnt==STARVE_MAX, ALU is granted and starve_cnt is cleared. starve_cnt also clears when alu_valid=0.
//   - hold=1: no pop, alu_ready=0, starve_cnt frozen, LSU pushes still accepted.
//   - Grant in cycle N -> we=1, waddr=rd, wdata=data in cycle N+1. Latency: ALU 1 cycle; LSU >=2 cycles from push.
//   - rd==0 grant: the result is consumed, but we=0, waddr=0, wdata=0 next cycle.
//   - No grant: we=0; waddr and wdata are forced to 0.
//   - WAW ordering across ALU and LSU to the same rd is the issue stage's responsibility. This block does not reorder within the LSU queue.
//   - rst mid-operation: queue flushed (pending results dropped); outputs are 0 the cycle after rst is sampled.
// CONFIGURATION
//   WB_BYPASS_EN defined: adds rf_raddr1/rf_raddr2 (in, AW), rf_rdata1/rf_rdata2 (in, XLEN),
//     and fwd_rdata1/fwd_rdata2 (out, XLEN).
//     fwd_rdataK = (we && waddr==rf_raddrK && rf_raddrK!=0) ? wdata : rf_rdataK. This path is combinational.
//     It gives write-then-read forwarding for same-cycle reads of a register being written.
//   WB_BYPASS_EN undefined: these ports are absent. Consumers read the regfile directly and see the new value one cycle later.
// STRUCTURE
//   Package wb_pkg: XLEN, AW, typedef reg_addr_t, typedef wb_req_t struct {reg_addr_t rd; logic [XLEN-1:0] data;}.
//   Sub-module wb_fifo: parameterised by DEPTH and element type wb_req_t; ports push/pop/full/empty/head.
//   The top level contains the arbiter, the starve counter, the output register and the optional bypass.
// TESTING (bench instantiates wb_stage plus regfile; STARVE_MAX=3, FIFO_DEPTH=4)
//   1 Reset: rst=1 for 2 cycles -> we=0, waddr=0, wdata=0, lsu_ready=0, alu_ready=0. After release, lsu_ready=1.
//   2 ALU alone: alu rd=5 data=0x32 at N -> alu_ready=1 at N; we=1, waddr=5, wdata=0x32 at N+1; regfile x5 reads 0x32 at N+2.
//   3 x0: alu rd=0 data=0xDEADBEEF -> alu_ready=1, we stays 0; regfile x0 reads 0.
//   4 Fill/order: hold=1, push LSU rd=1..4 data=10,20,30,40 -> lsu_ready=0 after 4th push.
//     Release hold with alu_valid=0 -> writes x1..x4 in order on consecutive cycles.
//   5 Starvation: queue holds 4 entries, alu_valid held with rd=9 -> grant order LSU, LSU, LSU, ALU, LSU.
//     x9 is written in the 4th write cycle.
//   6 Reset mid-op: queue holds 3 entries, assert rst 1 cycle -> no further writes; after release, lsu_ready=1 and the queue is empty.
//   7 WB_BYPASS_EN only: we=1, waddr=7, wdata=0x1234 with rf_raddr1=7 -> fwd_rdata1=0x1234 that cycle.
//     rf_raddr2=0 -> fwd_rdata2=rf_rdata2.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: register address and the rd/data request
// carried from the ALU or the LSU queue to the regfile write port.
package wb_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic is_x0(input reg_addr_t a);
    return a == '0;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// LSU result queue for the writeback stage: no fall-through, so a pushed entry
// becomes visible on head the cycle after the push. Synchronous active-high flush.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU vs queued LSU results into one registered regfile write
// per cycle. Optional same-cycle read forwarding is enabled by defining WB_BYPASS_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]   rf_raddr1,
  input  logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] fwd_rdata1,
  output logic [XLEN-1:0] fwd_rdata2
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t        lsu_req;
  wb_req_t        head;
  wb_req_t        win;
  logic           full;
  logic           empty;
  logic           push;
  logic           grant_alu;
  logic           grant_lsu;
  logic           starved;
  logic [SW-1:0]  starve_cnt;

  assign lsu_ready = !full && !rst;
  assign push      = lsu_valid && lsu_ready;
  assign lsu_req   = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wb_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (lsu_req),
    .pop   (grant_lsu),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Queue head normally wins; ALU takes the port when starved or when the queue is empty.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && !hold) begin
      if (alu_valid && (starved || empty)) grant_alu = 1'b1;
      else if (!empty)                     grant_lsu = 1'b1;
    end
  end

  assign alu_ready = grant_alu;
  assign win       = grant_alu ? '{rd: alu_rd, data: alu_data} : head;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!hold) begin
      if (!alu_valid || grant_alu) starve_cnt <= '0;
      else if (!starved)           starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 grants are consumed but leave the write port idle and zeroed.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if ((grant_alu || grant_lsu) && !is_x0(win.rd)) begin
      we    <= 1'b1;
      waddr <= win.rd;
      wdata <= win.data;
    end else begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_rdata1 = (we && waddr == rf_raddr1 && !is_x0(rf_raddr1)) ? wdata : rf_rdata1;
  assign fwd_rdata2 = (we && waddr == rf_raddr2 && !is_x0(rf_raddr2)) ? wdata : rf_rdata2;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_wb_stage;
  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } mreq_t;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef WB_BYPASS_EN
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] fwd_rdata1;
  logic [31:0] fwd_rdata2;
`endif

  wb_stage #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we(we), .waddr(waddr), .wdata(wdata)
`ifdef WB_BYPASS_EN
    , .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2)
`endif
  );

  // Regfile fed by the DUT write port
  logic [31:0] rf [32];
  always @(posedge clk) if (we && waddr != 5'd0) rf[waddr] <= wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  mreq_t       mq[$];
  int          mstarve;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] mrf [32];
  logic        seen_alu_ready;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic r, input logic h, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                      input logic [31:0] ld);
    logic  e_lr;
    logic  g_alu;
    logic  g_lsu;
    mreq_t hd;
    mreq_t nw;
    @(negedge clk);
    rst = r; hold = h;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
`ifdef WB_BYPASS_EN
    rf_raddr1 = ($urandom_range(0, 1) == 1) ? exp_waddr : 5'($urandom_range(0, 31));
    rf_raddr2 = 5'($urandom_range(0, 31));
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
`endif
    #1;
    e_lr  = !r && (mq.size() < DEPTH);
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (!r && !h) begin
      if (av && (mstarve >= STARVE || mq.size() == 0)) g_alu = 1'b1;
      else if (mq.size() > 0) g_lsu = 1'b1;
    end
    chk("alu_ready", alu_ready, g_alu);
    chk("lsu_ready", lsu_ready, e_lr);
    chk("we", we, exp_we);
    chk("waddr", waddr, exp_waddr);
    chk("wdata", wdata, exp_wdata);
`ifdef WB_BYPASS_EN
    chk("fwd1", fwd_rdata1,
        (exp_we && exp_waddr == rf_raddr1 && rf_raddr1 != 0) ? exp_wdata : rf_rdata1);
    chk("fwd2", fwd_rdata2,
        (exp_we && exp_waddr == rf_raddr2 && rf_raddr2 != 0) ? exp_wdata : rf_rdata2);
`endif
    seen_alu_ready = alu_ready;
    // advance the model across the coming rising edge
    if (exp_we) mrf[exp_waddr] = exp_wdata;
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    if (r) begin
      mq.delete();
      mstarve = 0;
    end else begin
      if (g_alu && ard != 0) begin
        exp_we = 1'b1; exp_waddr = ard; exp_wdata = ad;
      end
      if (g_lsu) begin
        hd = mq.pop_front();
        if (hd.rd != 0) begin
          exp_we = 1'b1; exp_waddr = hd.rd; exp_wdata = hd.data;
        end
      end
      if (lv && e_lr) begin
        nw.rd = lrd; nw.data = ld;
        mq.push_back(nw);
      end
      if (!h) begin
        if (!av || g_alu) mstarve = 0;
        else mstarve++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic h);
    step(1'b0, h, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
    chk("wr_we", we, 1'b1);
    chk("wr_addr", waddr, rd);
    chk("wr_data", wdata, d);
  endtask

  initial begin
    logic [4:0]  seq_rd [5];
    logic [31:0] seq_d  [5];
    logic [31:0] d9;
    n_pass = 0; n_total = 0;
    mstarve = 0;
    exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
    seen_alu_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      mrf[i] = '0;
    end
    rst = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
`ifdef WB_BYPASS_EN
    rf_raddr1 = '0; rf_raddr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
`endif

    // Reset held two cycles
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_we", we, 1'b0);
    chk("rst_waddr", waddr, 5'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    idle(1'b0);
    chk("post_rst_lsu_ready", lsu_ready, 1'b1);

    // ALU alone
    step(1'b0, 1'b0, 1'b1, 5'd5, 32'h32, 1'b0, 5'd0, 32'd0);
    chk("alu_grant", seen_alu_ready, 1'b1);
    expect_write(5'd5, 32'h32);
    idle(1'b0);
    chk("rf_x5", rf[5], 32'h32);

    // x0 write suppressed
    step(1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("x0_grant", seen_alu_ready, 1'b1);
    chk("x0_we", we, 1'b0);
    chk("x0_wdata", wdata, 32'd0);
    idle(1'b0);
    chk("rf_x0", rf[0], 32'd0);

    // Fill under hold, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(10 * i));
    chk("full_lsu_ready", lsu_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b0);
      expect_write(5'(i), 32'(10 * i));
    end
    idle(1'b0);
    chk("drained_we", we, 1'b0);

    // Starvation: LSU, LSU, LSU, ALU, LSU
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(11 + i), 32'h100 + 32'(i));
    d9 = $urandom;
    seq_rd = '{5'd11, 5'd12, 5'd13, 5'd9, 5'd14};
    seq_d  = '{32'h100, 32'h101, 32'h102, d9, 32'h103};
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 5'd9, d9, 1'b0, 5'd0, 32'd0);
      chk("starve_alu_ready", seen_alu_ready, (k == 3) ? 1'b1 : 1'b0);
      expect_write(seq_rd[k], seq_d[k]);
    end
    idle(1'b0);
    chk("rf_x9", rf[9], d9);

    // Reset with three entries pending
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h200 + 32'(i));
    step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("midrst_we", we, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("midrst_no_write", we, 1'b0);
    end
    chk("midrst_lsu_ready", lsu_ready, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(24 + i), 32'(i));
    chk("empty_after_rst_3", lsu_ready, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd27, 32'd3);
    chk("empty_after_rst_4", lsu_ready, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);

`ifdef WB_BYPASS_EN
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'd0);
    rf_raddr1 = 5'd7; rf_raddr2 = 5'd0;
    rf_rdata1 = 32'hAAAA5555; rf_rdata2 = 32'h0BADF00D;
    #1;
    chk("byp_fwd1", fwd_rdata1, 32'h1234);
    chk("byp_fwd2", fwd_rdata2, 32'h0BADF00D);
    alu_valid = 1'b0;
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
    end
    for (int i = 0; i < 8; i++) idle(1'b0);
    for (int i = 0; i < 32; i++) chk("rf_final", rf[i], mrf[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
